// File: rtl/k423_id_alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : k423_id_alu_issue_if
//  Purpose  : Bundles the signals of k423_id_alu_issue: upstream instruction
//             handshake, regfile read port and the EX-stage ALU bundle.
//  Modports : master - the issue stage (drives if_ready_o, rf_*_idx_o, ex/dec_*)
//             slave  - the surrounding pipeline (drives the *_i signals)
//  Revision : 1.0 - initial release
// ============================================================================
interface k423_id_alu_issue_if #(
  parameter int XLEN   = 32,
  parameter int INFO_W = 13
);
  logic              flush_i;
  logic              if_valid_i;
  logic              if_ready_o;
  logic [XLEN-1:0]   if_pc_i;
  logic [31:0]       if_inst_i;
  logic [4:0]        rf_rs1_idx_o;
  logic [4:0]        rf_rs2_idx_o;
  logic [XLEN-1:0]   rf_rs1_i;
  logic [XLEN-1:0]   rf_rs2_i;
  logic              ex_valid_o;
  logic              ex_ready_i;
  logic [XLEN-1:0]   pc_o;
  logic [1:0]        dec_grp_o;
  logic [INFO_W-1:0] dec_info_o;
  logic [4:0]        dec_rs1_idx_o;
  logic [4:0]        dec_rs2_idx_o;
  logic [4:0]        dec_rd_idx_o;
  logic              dec_rd_wen_o;
  logic [XLEN-1:0]   dec_rs1_o;
  logic [XLEN-1:0]   dec_rs2_o;
  logic [XLEN-1:0]   dec_imm_o;
  logic              dec_illegal_o;

  modport master (
    input  flush_i, if_valid_i, if_pc_i, if_inst_i, rf_rs1_i, rf_rs2_i, ex_ready_i,
    output if_ready_o, rf_rs1_idx_o, rf_rs2_idx_o, ex_valid_o, pc_o, dec_grp_o,
           dec_info_o, dec_rs1_idx_o, dec_rs2_idx_o, dec_rd_idx_o, dec_rd_wen_o,
           dec_rs1_o, dec_rs2_o, dec_imm_o, dec_illegal_o
  );

  modport slave (
    output flush_i, if_valid_i, if_pc_i, if_inst_i, rf_rs1_i, rf_rs2_i, ex_ready_i,
    input  if_ready_o, rf_rs1_idx_o, rf_rs2_idx_o, ex_valid_o, pc_o, dec_grp_o,
           dec_info_o, dec_rs1_idx_o, dec_rs2_idx_o, dec_rd_idx_o, dec_rd_wen_o,
           dec_rs1_o, dec_rs2_o, dec_imm_o, dec_illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/k423_id_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : k423_id_alu_issue
//  Purpose  : ID-stage issue of the ALU bundle. Decodes RV32I OP / OP-IMM /
//             LUI / AUIPC into a one-hot info vector plus operands and
//             immediate, and registers it into a 2-entry skid buffer.
//  Ports    : clk_i  - clock
//             rst_i  - asynchronous active-high reset
//             bus    - k423_id_alu_issue_if.master (handshakes, regfile, bundle)
//  Revision : 1.0 - initial release
// ============================================================================
module k423_id_alu_issue #(
  parameter int XLEN   = 32,
  parameter int INFO_W = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  k423_id_alu_issue_if.master   bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam int BIT_ADD = 0, BIT_SUB = 1, BIT_SLT = 2, BIT_SLTU = 3, BIT_AND = 4,
                 BIT_OR = 5, BIT_XOR = 6, BIT_SLL = 7, BIT_SRL = 8, BIT_SRA = 9,
                 BIT_LUI = 10, BIT_AUIPC = 11;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [1:0]        grp;
    logic [INFO_W-1:0] info;
    logic [4:0]        rs1_idx;
    logic [4:0]        rs2_idx;
    logic [4:0]        rd_idx;
    logic              rd_wen;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // ---------------------------------------------------------------- decode
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rs1_idx;
  logic [4:0]        rs2_idx;
  logic [4:0]        rd_idx;
  logic [INFO_W-2:0] f3_op;
  logic [INFO_W-2:0] op_vec;
  logic              rs2imm;
  logic              legal;
  logic [XLEN-1:0]   imm;
  bundle_t           new_entry;

  assign opcode  = bus.if_inst_i[6:0];
  assign rd_idx  = bus.if_inst_i[11:7];
  assign funct3  = bus.if_inst_i[14:12];
  assign rs1_idx = bus.if_inst_i[19:15];
  assign rs2_idx = bus.if_inst_i[24:20];
  assign funct7  = bus.if_inst_i[31:25];

  // Base funct3 -> operation mapping shared by OP and OP-IMM.
  always_comb begin
    f3_op = '0;
    case (funct3)
      3'b000:  f3_op[BIT_ADD]  = 1'b1;
      3'b001:  f3_op[BIT_SLL]  = 1'b1;
      3'b010:  f3_op[BIT_SLT]  = 1'b1;
      3'b011:  f3_op[BIT_SLTU] = 1'b1;
      3'b100:  f3_op[BIT_XOR]  = 1'b1;
      3'b101:  f3_op[BIT_SRL]  = 1'b1;
      3'b110:  f3_op[BIT_OR]   = 1'b1;
      default: f3_op[BIT_AND]  = 1'b1;
    endcase
  end

  always_comb begin
    op_vec = '0;
    rs2imm = 1'b0;
    imm    = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0)
          op_vec = f3_op;
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          op_vec[BIT_SUB] = 1'b1;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          op_vec[BIT_SRA] = 1'b1;
      end
      OPC_OPIMM: begin
        rs2imm = 1'b1;
        imm    = XLEN'($signed(bus.if_inst_i[31:20]));
        // Only the shifts constrain funct7; there it selects SRL vs SRA.
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0) op_vec = f3_op;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0)        op_vec = f3_op;
          else if (funct7 == F7_ALT) op_vec[BIT_SRA] = 1'b1;
        end else begin
          op_vec = f3_op;
        end
      end
      OPC_LUI: begin
        rs2imm          = 1'b1;
        op_vec[BIT_LUI] = 1'b1;
        imm             = XLEN'($signed({bus.if_inst_i[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        rs2imm            = 1'b1;
        op_vec[BIT_AUIPC] = 1'b1;
        imm               = XLEN'($signed({bus.if_inst_i[31:12], 12'b0}));
      end
      default: ;
    endcase
    legal = |op_vec;
  end

  always_comb begin
    new_entry         = '0;
    new_entry.pc      = bus.if_pc_i;
    new_entry.grp     = legal ? 2'b01 : 2'b00;
    new_entry.info    = legal ? {rs2imm, op_vec} : '0;
    new_entry.rs1_idx = rs1_idx;
    new_entry.rs2_idx = rs2_idx;
    new_entry.rd_idx  = rd_idx;
    new_entry.rd_wen  = legal && (rd_idx != 5'd0);
    new_entry.rs1     = (rs1_idx == 5'd0) ? '0 : bus.rf_rs1_i;
    new_entry.rs2     = (rs2_idx == 5'd0) ? '0 : bus.rf_rs2_i;
    new_entry.imm     = legal ? imm : '0;
    new_entry.illegal = ~legal;
  end

  // ----------------------------------------------------------- skid buffer
  state_t  state_q, state_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    ex_valid_q, ex_valid_d;
  logic    if_ready_q, if_ready_d;
  logic    accept;

  assign accept = bus.if_valid_i & if_ready_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (bus.flush_i) begin
      // Flush wins over a same-cycle accept; stale data is left in place.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            out_d   = new_entry;
          end
        end
        S_ONE: begin
          if (accept && bus.ex_ready_i) begin
            out_d = new_entry;
          end else if (accept) begin
            state_d = S_TWO;
            skid_d  = new_entry;
          end else if (bus.ex_ready_i) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (bus.ex_ready_i) begin
            state_d = S_ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // Handshake flags follow the next state so they come straight from flops.
    ex_valid_d = (state_d != S_EMPTY);
    if_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      ex_valid_q <= 1'b0;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      ex_valid_q <= ex_valid_d;
      if_ready_q <= if_ready_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.rf_rs1_idx_o  = rs1_idx;
  assign bus.rf_rs2_idx_o  = rs2_idx;
  assign bus.if_ready_o    = if_ready_q;
  assign bus.ex_valid_o    = ex_valid_q;
  assign bus.pc_o          = out_q.pc;
  assign bus.dec_grp_o     = out_q.grp;
  assign bus.dec_info_o    = out_q.info;
  assign bus.dec_rs1_idx_o = out_q.rs1_idx;
  assign bus.dec_rs2_idx_o = out_q.rs2_idx;
  assign bus.dec_rd_idx_o  = out_q.rd_idx;
  assign bus.dec_rd_wen_o  = out_q.rd_wen;
  assign bus.dec_rs1_o     = out_q.rs1;
  assign bus.dec_rs2_o     = out_q.rs2;
  assign bus.dec_imm_o     = out_q.imm;
  assign bus.dec_illegal_o = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_k423_id_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_k423_id_alu_issue
//  Purpose  : Self-checking bench for k423_id_alu_issue. A queue-based model
//             of the issue buffer plus a mnemonic-level decoder predict every
//             bundle leaving the block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_k423_id_alu_issue;

  localparam int XLEN   = 32;
  localparam int INFO_W = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;

  k423_id_alu_issue_if #(.XLEN(XLEN), .INFO_W(INFO_W)) bus ();

  k423_id_alu_issue #(.XLEN(XLEN), .INFO_W(INFO_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  grp;
    logic [12:0] info;
    logic [4:0]  rs1i, rs2i, rdi;
    logic        wen;
    logic [31:0] rs1, rs2, imm;
    logic        ill;
    logic        chk_ops;   // legal: indices/rs1 operand defined
    logic        chk_rs2;   // register-register op: rs2 operand defined
    logic        chk_imm;   // immediate-type op: imm defined
  } ent_t;

  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Operation number by funct3 (bit positions of the info vector).
  int f3_op [8] = '{0, 7, 2, 3, 6, 8, 5, 4};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ref_decode(input logic [31:0] inst, pc, r1, r2);
    ent_t e;
    int   op;
    logic immop;
    logic [6:0] opc = inst[6:0];
    logic [2:0] f3  = inst[14:12];
    logic [6:0] f7  = inst[31:25];
    op    = -1;
    immop = 1'b0;
    e.imm = 32'd0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) op = f3_op[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 9;
    end else if (opc == 7'h13) begin
      immop = 1'b1;
      e.imm = {{20{inst[31]}}, inst[31:20]};
      if (f3 == 3'd1) op = (f7 == 7'h00) ? 7 : -1;
      else if (f3 == 3'd5) op = (f7 == 7'h00) ? 8 : (f7 == 7'h20) ? 9 : -1;
      else op = f3_op[f3];
    end else if (opc == 7'h37 || opc == 7'h17) begin
      immop = 1'b1;
      op    = (opc == 7'h37) ? 10 : 11;
      e.imm = {inst[31:12], 12'h000};
    end
    e.pc   = pc;
    e.rs1i = inst[19:15];
    e.rs2i = inst[24:20];
    e.rdi  = inst[11:7];
    e.rs1  = (inst[19:15] == 0) ? 32'd0 : r1;
    e.rs2  = (inst[24:20] == 0) ? 32'd0 : r2;
    if (op >= 0) begin
      e.info    = 13'(1 << op) | (immop ? 13'h1000 : 13'h0000);
      e.grp     = 2'b01;
      e.wen     = (inst[11:7] != 0);
      e.ill     = 1'b0;
      e.chk_ops = 1'b1;
      e.chk_rs2 = (opc == 7'h33);
      e.chk_imm = immop;
    end else begin
      e.info    = 13'h0;
      e.grp     = 2'b00;
      e.wen     = 1'b0;
      e.ill     = 1'b1;
      e.chk_ops = 1'b0;
      e.chk_rs2 = 1'b0;
      e.chk_imm = 1'b0;
    end
    return e;
  endfunction

  task automatic check_out();
    chk("ex_valid", 64'(bus.ex_valid_o), 64'(q.size() > 0));
    chk("if_ready", 64'(bus.if_ready_o), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("pc",      bus.pc_o,          q[0].pc);
      chk("grp",     bus.dec_grp_o,     q[0].grp);
      chk("info",    bus.dec_info_o,    q[0].info);
      chk("rd_wen",  bus.dec_rd_wen_o,  q[0].wen);
      chk("illegal", bus.dec_illegal_o, q[0].ill);
      if (q[0].chk_ops) begin
        chk("rs1_idx", bus.dec_rs1_idx_o, q[0].rs1i);
        chk("rs2_idx", bus.dec_rs2_idx_o, q[0].rs2i);
        chk("rd_idx",  bus.dec_rd_idx_o,  q[0].rdi);
        chk("rs1",     bus.dec_rs1_o,     q[0].rs1);
      end
      if (q[0].chk_rs2) chk("rs2", bus.dec_rs2_o, q[0].rs2);
      if (q[0].chk_imm) chk("imm", bus.dec_imm_o, q[0].imm);
    end
  endtask

  // One clock of stimulus; called and returning at a falling edge.
  task automatic cycle(input logic v, input logic [31:0] inst, pc, r1, r2,
                       input logic er, input logic fl);
    ent_t e;
    logic acc, pop;
    bus.if_valid_i = v;
    bus.if_inst_i  = inst;
    bus.if_pc_i    = pc;
    bus.rf_rs1_i   = r1;
    bus.rf_rs2_i   = r2;
    bus.ex_ready_i = er;
    bus.flush_i    = fl;
    e   = ref_decode(inst, pc, r1, r2);
    acc = v && (q.size() < 2) && !fl;
    pop = (q.size() > 0) && er && !fl;
    #1;
    chk("rf_rs1_idx", bus.rf_rs1_idx_o, inst[19:15]);
    chk("rf_rs2_idx", bus.rf_rs2_idx_o, inst[24:20]);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    check_out();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom();
    case ($urandom_range(0, 5))
      0: i[6:0] = 7'h33;
      1: i[6:0] = 7'h13;
      2: i[6:0] = 7'h37;
      3: i[6:0] = 7'h17;
      4: i[6:0] = 7'h33;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      2: i[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) i[19:15] = 5'd0;
    if ($urandom_range(0, 7) == 0) i[24:20] = 5'd0;
    if ($urandom_range(0, 7) == 0) i[11:7]  = 5'd0;
    return i;
  endfunction

  initial begin
    bus.if_valid_i = 1'b0;
    bus.if_inst_i  = 32'h0;
    bus.if_pc_i    = 32'h0;
    bus.rf_rs1_i   = 32'h0;
    bus.rf_rs2_i   = 32'h0;
    bus.ex_ready_i = 1'b0;
    bus.flush_i    = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ex_valid", bus.ex_valid_o, 0);
    chk("rst_if_ready", bus.if_ready_o, 1);
    chk("rst_pc",       bus.pc_o, 0);
    chk("rst_info",     bus.dec_info_o, 0);
    chk("rst_imm",      bus.dec_imm_o, 0);
    chk("rst_rs1",      bus.dec_rs1_o, 0);
    chk("rst_grp",      bus.dec_grp_o, 0);
    chk("rst_illegal",  bus.dec_illegal_o, 0);
    rst = 1'b0;

    // Directed decodes
    cycle(1, 32'hFFD08293, 32'h100, 32'd10, 32'h55, 1, 0);   // ADDI x5,x1,-3
    chk("addi_info", bus.dec_info_o, 13'h1001);
    chk("addi_imm",  bus.dec_imm_o, 32'hFFFF_FFFD);
    chk("addi_rs1",  bus.dec_rs1_o, 32'd10);
    chk("addi_rd",   bus.dec_rd_idx_o, 5);
    chk("addi_wen",  bus.dec_rd_wen_o, 1);
    cycle(1, 32'h4071D113, 32'h104, 32'h77, 32'h99, 1, 0);   // SRAI x2,x3,7
    chk("srai_info", bus.dec_info_o, 13'h1200);
    chk("srai_shamt", bus.dec_rs2_idx_o, 7);
    cycle(1, 32'h403100B3, 32'h108, 32'd5, 32'h1234, 1, 0);  // SUB x1,x2,x3
    chk("sub_info", bus.dec_info_o, 13'h0002);
    chk("sub_rs2",  bus.dec_rs2_o, 32'h1234);
    cycle(1, 32'h12345217, 32'h8000_0010, 32'h1, 32'h2, 1, 0); // AUIPC x4
    chk("auipc_info", bus.dec_info_o, 13'h1800);
    chk("auipc_imm",  bus.dec_imm_o, 32'h1234_5000);
    chk("auipc_pc",   bus.pc_o, 32'h8000_0010);
    cycle(1, 32'hABCDE037, 32'h114, 32'h3, 32'h4, 1, 0);     // LUI x0
    chk("lui_info", bus.dec_info_o, 13'h1400);
    chk("lui_wen",  bus.dec_rd_wen_o, 0);
    cycle(1, 32'h0000007F, 32'h118, 32'h5, 32'h6, 1, 0);     // bad opcode
    chk("bad_ill",  bus.dec_illegal_o, 1);
    chk("bad_info", bus.dec_info_o, 0);
    cycle(1, 32'h023100B3, 32'h11C, 32'h7, 32'h8, 1, 0);     // MUL
    chk("mul_ill", bus.dec_illegal_o, 1);
    chk("mul_grp", bus.dec_grp_o, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Back-to-back under backpressure: third is refused, order preserved
    cycle(1, 32'h00108093, 32'h200, 32'h11, 32'h0, 0, 0);
    cycle(1, 32'h00210113, 32'h204, 32'h22, 32'h0, 0, 0);
    chk("b2b_ready_low", bus.if_ready_o, 0);
    cycle(1, 32'h00318193, 32'h208, 32'h33, 32'h0, 0, 0);
    repeat (3) cycle(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    chk("b2b_drained", bus.ex_valid_o, 0);

    // Flush while full with a valid instruction presented
    cycle(1, 32'h00108093, 32'h300, 32'h1, 32'h0, 0, 0);
    cycle(1, 32'h00210113, 32'h304, 32'h2, 32'h0, 0, 0);
    cycle(1, 32'h00318193, 32'h308, 32'h3, 32'h0, 0, 1);
    chk("flush_valid", bus.ex_valid_o, 0);
    chk("flush_ready", bus.if_ready_o, 1);
    repeat (2) cycle(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom(), $urandom(), $urandom(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-stream
    cycle(1, 32'h00108093, 32'h400, 32'h1, 32'h0, 0, 0);
    cycle(1, 32'h00210113, 32'h404, 32'h2, 32'h0, 0, 0);
    bus.if_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.ex_valid_o, 0);
    chk("arst_ready", bus.if_ready_o, 1);
    chk("arst_info",  bus.dec_info_o, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 32'hFFD08293, 32'h500, 32'd10, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
